// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef enum logic [1:0] {
        IDX_SEC_1S  = 2'd0,
        IDX_SEC_10S = 2'd1,
        IDX_MIN_1S  = 2'd2,
        IDX_MIN_10S = 2'd3
    } digit_idx_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_display_scanner.sv
// 4-digit common-anode display scanner: per-slot anode scan with blanking,
// frame-coherent digit snapshot, leading-zero suppression and done-blink.
module seg7_display_scanner
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [3:0] sec_1s,
    input  logic [3:0] sec_10s,
    input  logic [3:0] min_1s,
    input  logic [3:0] min_10s,
    input  logic       tick_1Hz,
    input  logic       timer_done,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic             blink_q, blink_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             slot_end;
    logic [6:0]       cur_seg;

    assign slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));

    bcd_to_seg7 u_dec (
        .bcd_i (snap_q[idx_q]),
        .seg_o (cur_seg)
    );

    always_comb begin
        cnt_d   = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d   = slot_end ? digit_idx_t'(idx_q + 2'd1) : idx_q;
        // The snapshot is taken as the last slot of a frame ends, so a whole frame shows one coherent time.
        snap_d  = (slot_end && idx_q == IDX_MIN_10S) ? {min_10s, min_1s, sec_10s, sec_1s} : snap_q;
        blink_d = timer_done ? (blink_q ^ tick_1Hz) : 1'b0;

        seg_d = cur_seg;
        if (int'(cnt_q) < BLANK_CYCLES) begin
            an_d = AN_OFF;
        end else if (blink_q) begin
            an_d = AN_OFF;
        end else if (idx_q == IDX_MIN_10S && LZ_SUPPRESS != 0 && snap_q[IDX_MIN_10S] == 4'd0) begin
            an_d = AN_OFF;
        end else begin
            an_d = ~(4'b0001 << idx_q);
        end
        dp_d = !(idx_q == IDX_MIN_1S && an_d[2] == 1'b0);
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= IDX_SEC_1S;
            snap_q  <= '0;
            blink_q <= 1'b0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            an_q    <= AN_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_display_scanner.sv
// Scoreboard bench for seg7_display_scanner: one instance with leading-zero
// suppression and one without, both driven from the same random stimulus.
module tb_seg7_display_scanner;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int NCYC = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       td, tick;
    logic [3:0] s1, s10, m1, m10;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [3:0] an_nolz;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         t;
    logic [3:0] snap[4];
    bit         blink;

    always #5 clk = ~clk;

    seg7_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_SUPPRESS(1)) dut_lz (
        .clk_100MHz(clk), .reset(rst), .sec_1s(s1), .sec_10s(s10), .min_1s(m1), .min_10s(m10),
        .tick_1Hz(tick), .timer_done(td), .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    seg7_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_SUPPRESS(0)) dut_nolz (
        .clk_100MHz(clk), .reset(rst), .sec_1s(s1), .sec_10s(s10), .min_1s(m1), .min_10s(m10),
        .tick_1Hz(tick), .timer_done(td), .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic model_reset();
        t = 0;
        blink = 0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    endtask

    // Reference: slot position follows from elapsed cycles since reset release.
    task automatic push_expected();
        int   cnt, idx;
        exp_t e;
        cnt = t % SD;
        idx = (t / SD) % 4;
        e.seg = seg_of(snap[idx]);
        if (cnt < BL || blink) begin
            e.an = 4'b1111;
            e.an_nolz = 4'b1111;
        end else begin
            e.an_nolz = 4'b1111;
            e.an_nolz[idx] = 1'b0;
            e.an = (idx == 3 && snap[3] == 4'd0) ? 4'b1111 : e.an_nolz;
        end
        e.dp = (idx == 2 && e.an[2] == 1'b0) ? 1'b0 : 1'b1;
        q.push_back(e);
        if (cnt == SD - 1 && idx == 3) begin
            snap[0] = s1; snap[1] = s10; snap[2] = m1; snap[3] = m10;
        end
        blink = td ? (blink ^ tick) : 1'b0;
        t++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seg"}, 32'(seg_a), 32'h7F);
        chk({tag, "_dp"},  32'(dp_a),  32'h1);
        chk({tag, "_an"},  32'(an_a),  32'hF);
        chk({tag, "_an_nolz"}, 32'(an_b), 32'hF);
    endtask

    // Monitor: every post-edge sample is checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                chk("seg", 32'(seg_a), 32'(e.seg));
                chk("dp", 32'(dp_a), 32'(e.dp));
                chk("an", 32'(an_a), 32'(e.an));
                chk("seg_nolz", 32'(seg_b), 32'(e.seg));
                chk("dp_nolz", 32'(dp_b), 32'(e.dp));
                chk("an_nolz", 32'(an_b), 32'(e.an_nolz));
            end
        end
    end

    initial begin
        rst = 1'b1; td = 1'b0; tick = 1'b0;
        s1 = 4'd0; s10 = 4'd0; m1 = 4'd0; m10 = 4'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == 333) begin
                // Asynchronous reset in the middle of a slot.
                rst = 1'b1;
                q.delete();
                #1;
                chk_reset_outputs("rst_async");
                repeat (2) @(negedge clk);
                chk_reset_outputs("rst_hold");
                rst = 1'b0;
                model_reset();
            end

            if (cyc < 100) begin
                m10 = 4'd1; m1 = 4'd2; s10 = 4'd3; s1 = 4'd4;
            end else if (cyc < 200) begin
                m10 = 4'd0; m1 = 4'd5; s10 = 4'd7; s1 = 4'hB;
            end else if ($urandom_range(0, 23) == 0) begin
                m10 = ($urandom_range(0, 1) == 0) ? 4'd0 : rand_digit();
                m1 = rand_digit(); s10 = rand_digit(); s1 = rand_digit();
            end

            td = ((cyc >= 1000 && cyc < 1500) || (cyc >= 1700 && cyc < 1900)) ? 1'b1 : 1'b0;
            if (cyc >= 950 && cyc < 1600) tick = (cyc % 100 == 0) ? 1'b1 : 1'b0;
            else if (cyc >= 1600) tick = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
            else tick = 1'b0;

            push_expected();
            @(negedge clk);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
